// File: rtl/wb_stage_if.sv
// Writeback-stage bus: EX handshake, data-memory load response and register-file write port.
interface wb_stage_if #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5
);
   logic              ex_valid;
   logic              ex_ready;
   logic              ex_is_ld;
   logic [REG_AW-1:0] ex_rd;
   logic [DATA_W-1:0] ex_res;
   logic              mem_rsp_valid;
   logic [DATA_W-1:0] mem_rsp_data;
   logic              wb_we;
   logic [REG_AW-1:0] wb_rd;
   logic [DATA_W-1:0] wb_wbv;
   logic              ld_err;
   logic [15:0]       wb_cnt;

   modport master (
      output ex_valid, ex_is_ld, ex_rd, ex_res, mem_rsp_valid, mem_rsp_data,
      input  ex_ready, wb_we, wb_rd, wb_wbv, ld_err, wb_cnt
   );
   modport slave (
      input  ex_valid, ex_is_ld, ex_rd, ex_res, mem_rsp_valid, mem_rsp_data,
      output ex_ready, wb_we, wb_rd, wb_wbv, ld_err, wb_cnt
   );
endinterface

// File: rtl/wb_stage.sv
// Writeback stage: retires ALU results immediately, holds EX off while a load is outstanding.
// Optional WB_SANITIZE_EN: write address/value read 0 whenever wb_we is low.
module wb_stage #(
   parameter int DATA_W     = 32,
   parameter int REG_AW     = 5,
   parameter int LD_TIMEOUT = 15
) (
   input  logic          clk,
   input  logic          rst_n,
   wb_stage_if.slave     bus
);
   typedef enum logic {IDLE, WAIT_LD} state_t;

   localparam logic [7:0] TO_LAST = 8'(LD_TIMEOUT - 1);

   state_t            state, state_nxt;
   logic [7:0]        tcnt, tcnt_nxt;
   logic [REG_AW-1:0] pend_rd, pend_nxt;
   logic              wr_go, we_nxt, to_hit;
   logic [REG_AW-1:0] wr_rd;
   logic [DATA_W-1:0] wr_val;

   logic              we_q, err_q;
   logic [REG_AW-1:0] rd_q;
   logic [DATA_W-1:0] wbv_q;
   logic [15:0]       cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         tcnt    <= '0;
         pend_rd <= '0;
      end else begin
         state   <= state_nxt;
         tcnt    <= tcnt_nxt;
         pend_rd <= pend_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      tcnt_nxt  = tcnt;
      pend_nxt  = pend_rd;
      wr_go     = 1'b0;
      wr_rd     = '0;
      wr_val    = '0;
      to_hit    = 1'b0;
      case (state)
         IDLE: begin
            if (bus.ex_valid) begin
               if (bus.ex_is_ld) begin
                  pend_nxt  = bus.ex_rd;
                  tcnt_nxt  = '0;
                  state_nxt = WAIT_LD;
               end else begin
                  wr_go  = 1'b1;
                  wr_rd  = bus.ex_rd;
                  wr_val = bus.ex_res;
               end
            end
         end
         WAIT_LD: begin
            // A response in the final waiting cycle still beats the timeout.
            if (bus.mem_rsp_valid) begin
               wr_go     = 1'b1;
               wr_rd     = pend_rd;
               wr_val    = bus.mem_rsp_data;
               state_nxt = IDLE;
            end else begin
               tcnt_nxt = tcnt + 8'd1;
               if (tcnt == TO_LAST) begin
                  to_hit    = 1'b1;
                  state_nxt = IDLE;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
      // x0 is hardwired: the op retires but nothing is written.
      we_nxt = wr_go && (wr_rd != '0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         we_q  <= 1'b0;
         rd_q  <= '0;
         wbv_q <= '0;
         err_q <= 1'b0;
         cnt_q <= '0;
      end else begin
         we_q <= we_nxt;
`ifdef WB_SANITIZE_EN
         rd_q  <= we_nxt ? wr_rd  : '0;
         wbv_q <= we_nxt ? wr_val : '0;
`else
         if (wr_go) begin
            rd_q  <= wr_rd;
            wbv_q <= wr_val;
         end
`endif
         if (to_hit) err_q <= 1'b1;
         if (we_nxt) cnt_q <= cnt_q + 16'd1;
      end
   end

   assign bus.ex_ready = (state == IDLE);
   assign bus.wb_we    = we_q;
   assign bus.wb_rd    = rd_q;
   assign bus.wb_wbv   = wbv_q;
   assign bus.ld_err   = err_q;
   assign bus.wb_cnt   = cnt_q;
endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: directed table, load wait/timeout sequences, reset-in-wait, random ops vs transaction model.
module tb_wb_stage;
   localparam int DW = 32;
   localparam int AW = 5;
   localparam int TO = 15;
`ifdef WB_SANITIZE_EN
   localparam bit SAN = 1'b1;
`else
   localparam bit SAN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   wb_stage_if #(.DATA_W(DW), .REG_AW(AW)) bus ();
   wb_stage #(.DATA_W(DW), .REG_AW(AW), .LD_TIMEOUT(TO)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus)
   );

   int total = 0;
   int bad   = 0;

   // Model of what the write port should show (last written address/value, counters).
   logic [AW-1:0] m_rd;
   logic [DW-1:0] m_wbv;
   logic [15:0]   m_cnt;
   logic          m_err;

   typedef struct {
      logic [AW-1:0] rd;
      logic [DW-1:0] res;
      logic          exp_we;
      logic [AW-1:0] exp_rd;
      logic [DW-1:0] exp_wbv;
   } alu_vec_t;
   alu_vec_t vecs[5];

   task automatic chk(string nm, logic [63:0] got, logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h", nm, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      m_rd = '0; m_wbv = '0; m_cnt = '0; m_err = 1'b0;
   endtask

   task automatic model_write(logic [AW-1:0] rd, logic [DW-1:0] v);
      m_rd = rd; m_wbv = v;
      if (rd != '0) m_cnt++;
   endtask

   task automatic chk_port(string nm, logic we);
      chk({nm, ".we"}, 64'(bus.wb_we), 64'(we));
      chk({nm, ".rd"}, 64'(bus.wb_rd), (SAN && !we) ? 64'd0 : 64'(m_rd));
      chk({nm, ".wbv"}, 64'(bus.wb_wbv), (SAN && !we) ? 64'd0 : 64'(m_wbv));
      chk({nm, ".err"}, 64'(bus.ld_err), 64'(m_err));
      chk({nm, ".cnt"}, 64'(bus.wb_cnt), 64'(m_cnt));
   endtask

   task automatic alu_op(logic [AW-1:0] rd, logic [DW-1:0] v);
      chk("alu.ready", 64'(bus.ex_ready), 64'd1);
      bus.ex_valid = 1'b1; bus.ex_is_ld = 1'b0; bus.ex_rd = rd; bus.ex_res = v;
      tick();
      bus.ex_valid = 1'b0;
      model_write(rd, v);
      chk_port("alu", rd != '0);
   endtask

   // d = WAIT_LD cycle (1..TO) in which the response arrives; anything else = never.
   task automatic ld_op(logic [AW-1:0] rd, logic [DW-1:0] data, int d);
      chk("ld.ready0", 64'(bus.ex_ready), 64'd1);
      bus.ex_valid = 1'b1; bus.ex_is_ld = 1'b1; bus.ex_rd = rd; bus.ex_res = $urandom;
      tick();
      bus.ex_valid = 1'b0;
      chk_port("ld.acc", 1'b0);
      for (int k = 1; k <= TO; k++) begin
         chk("ld.wait_ready", 64'(bus.ex_ready), 64'd0);
         if (k == d) begin
            bus.mem_rsp_valid = 1'b1; bus.mem_rsp_data = data;
            tick();
            bus.mem_rsp_valid = 1'b0;
            model_write(rd, data);
            chk_port("ld.rsp", rd != '0);
            chk("ld.ready1", 64'(bus.ex_ready), 64'd1);
            return;
         end
         tick();
         if (k < TO) chk_port("ld.wait", 1'b0);
      end
      m_err = 1'b1;
      chk_port("ld.timeout", 1'b0);
      chk("ld.to_ready", 64'(bus.ex_ready), 64'd1);
   endtask

   initial begin
      bus.ex_valid = 1'b0; bus.ex_is_ld = 1'b0; bus.ex_rd = '0; bus.ex_res = '0;
      bus.mem_rsp_valid = 1'b0; bus.mem_rsp_data = '0;
      model_reset();

      vecs[0] = '{5'd3, 32'h0000_00AA, 1'b1, 5'd3, 32'h0000_00AA};
      vecs[1] = '{5'd1, 32'h0000_0011, 1'b1, 5'd1, 32'h0000_0011};
      vecs[2] = '{5'd2, 32'h0000_0022, 1'b1, 5'd2, 32'h0000_0022};
      vecs[3] = '{5'd3, 32'h0000_0033, 1'b1, 5'd3, 32'h0000_0033};
      vecs[4] = '{5'd0, 32'h0000_0055, 1'b0, 5'd0, SAN ? 32'h0 : 32'h0000_0055};

      // Reset state
      #12;
      chk_port("rst", 1'b0);
      rst_n = 1'b1;
      tick();
      chk("rst.ready", 64'(bus.ex_ready), 64'd1);

      // Directed ALU table, applied back-to-back
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("vec%0d.ready", i), 64'(bus.ex_ready), 64'd1);
         bus.ex_valid = 1'b1; bus.ex_is_ld = 1'b0;
         bus.ex_rd = vecs[i].rd; bus.ex_res = vecs[i].res;
         tick();
         if (vecs[i].exp_we) m_cnt++;
         m_rd = vecs[i].rd; m_wbv = vecs[i].res;
         chk($sformatf("vec%0d.we", i), 64'(bus.wb_we), 64'(vecs[i].exp_we));
         chk($sformatf("vec%0d.rd", i), 64'(bus.wb_rd), 64'(vecs[i].exp_rd));
         chk($sformatf("vec%0d.wbv", i), 64'(bus.wb_wbv), 64'(vecs[i].exp_wbv));
         chk($sformatf("vec%0d.cnt", i), 64'(bus.wb_cnt), 64'(m_cnt));
      end
      bus.ex_valid = 1'b0;
      tick();
      chk_port("idle", 1'b0);

      // Stray response in IDLE is ignored
      bus.mem_rsp_valid = 1'b1; bus.mem_rsp_data = 32'h1234_5678;
      tick();
      bus.mem_rsp_valid = 1'b0;
      chk_port("idle_rsp", 1'b0);
      chk("idle_rsp.ready", 64'(bus.ex_ready), 64'd1);

      ld_op(5'd5, 32'hDEAD_BEEF, 4);
      ld_op(5'd6, 32'hCAFE_0006, TO);   // response in the very last waiting cycle wins
      ld_op(5'd7, 32'h0, 0);            // timeout
      alu_op(5'd9, 32'h0000_0099);
      ld_op(5'd0, 32'h0BAD_0000, 2);    // load to x0: consumed, no write

      // Reset in the middle of a load wait, then a late response
      bus.ex_valid = 1'b1; bus.ex_is_ld = 1'b1; bus.ex_rd = 5'd4;
      tick();
      bus.ex_valid = 1'b0;
      tick(); tick();
      chk("mid.ready", 64'(bus.ex_ready), 64'd0);
      rst_n = 1'b0;
      #2;
      model_reset();
      chk_port("mid.rst", 1'b0);
      #3 rst_n = 1'b1;
      tick();
      bus.mem_rsp_valid = 1'b1; bus.mem_rsp_data = 32'hFEED_FACE;
      tick();
      bus.mem_rsp_valid = 1'b0;
      chk_port("late_rsp", 1'b0);
      chk("late_rsp.ready", 64'(bus.ex_ready), 64'd1);

      // Random ops against the transaction model
      for (int n = 0; n < 200; n++) begin
         int unsigned kind;
         logic [AW-1:0] rd;
         kind = $urandom_range(0, 9);
         rd = ($urandom_range(0, 7) == 0) ? 5'd0 : AW'($urandom);
         if (kind < 5) begin
            alu_op(rd, $urandom);
         end else if (kind < 9) begin
            ld_op(rd, $urandom, int'($urandom_range(1, TO + 3)));
         end else begin
            bus.mem_rsp_valid = $urandom_range(0, 1) != 0; bus.mem_rsp_data = $urandom;
            tick();
            bus.mem_rsp_valid = 1'b0;
            chk_port("rnd.gap", 1'b0);
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog expired");
   end
endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Writeback stage directly downstream of the execute stage.
- Accepts one retiring instruction per handshake from EX: either an ALU result or a load whose data returns later from data memory.
- Selects the writeback value (load data vs. ALU result) and drives a registered register-file write port.
- Stalls EX while a load is outstanding; flags loads that never return.

Parameters:
- DATA_W, 32, width of results and load data.
- REG_AW, 5, register-file address width.
- LD_TIMEOUT, 15, max cycles spent in WAIT_LD before the load is aborted (1..255).

Ports:
- clk  input  1  clock, all state updates on posedge.
- rst_n  input  1  asynchronous active-low reset.
- ex_valid  input  1  EX presents an instruction.
- ex_ready  output  1  stage can accept; transfer when ex_valid && ex_ready.
- ex_is_ld  input  1  instruction is a load (result comes from mem_rsp_data).
- ex_rd  input  REG_AW  destination register.
- ex_res  input  DATA_W  ALU result (ignored for loads).
- mem_rsp_valid  input  1  data-memory load response strobe.
- mem_rsp_data  input  DATA_W  load data.
- wb_we  output  1  register-file write enable, one-cycle pulse.
- wb_rd  output  REG_AW  write address.
- wb_wbv  output  DATA_W  write value.
- ld_err  output  1  sticky: a load timed out.
- wb_cnt  output  16  count of completed writebacks, wraps 0xFFFF->0.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; wb_we=0, wb_rd=0, wb_wbv=0, ld_err=0, wb_cnt=0, timeout counter=0. ex_ready=1 once reset is released.
- States: IDLE, WAIT_LD.
- ex_ready = (state==IDLE), combinational from state only. Never depends on ex_valid.
- IDLE, transfer with ex_is_ld=0:
  - Next cycle: wb_we=1, wb_rd=ex_rd, wb_wbv=ex_res. Latency 1.
  - Stay in IDLE. Back-to-back transfers give back-to-back wb_we pulses.
- IDLE, transfer with ex_is_ld=1:
  - Capture ex_rd into a pending register; clear timeout counter; go to WAIT_LD.
  - wb_we=0 next cycle.
- WAIT_LD:
  - ex_ready=0.
  - When mem_rsp_valid=1: next cycle wb_we=1, wb_rd=pending rd, wb_wbv=mem_rsp_data; go to IDLE.
  - Otherwise the counter increments. When it reaches LD_TIMEOUT (i.e. LD_TIMEOUT cycles spent in WAIT_LD with no response): set ld_err=1 (sticky until reset), no write, go to IDLE.
  - A response arriving in the same cycle the counter hits LD_TIMEOUT wins: write occurs, ld_err unchanged.
- mem_rsp_valid while in IDLE: ignored, no state change, no write.
- Destination register 0: the transfer or response is consumed normally, but wb_we stays 0 and wb_cnt does not increment. wb_rd/wb_wbv still update.
- wb_cnt increments by 1 in the cycle wb_we=1.
- wb_we is high for exactly one cycle per completed writeback. wb_rd/wb_wbv hold their last values when wb_we=0 (unless the optional feature is enabled).
- Reset asserted in WAIT_LD: the pending load is dropped. A late mem_rsp_valid after reset is ignored (state is IDLE).
- All outputs except ex_ready are registered.

Optional Feature:
- Macro: WB_SANITIZE_EN.
- Defined: wb_wbv and wb_rd are forced to 0 in every cycle where wb_we=0, so no stale result is visible on the write port between writebacks. Also, a timed-out load writes 0 into the wb_wbv register (still with wb_we=0).
- Undefined: wb_wbv/wb_rd hold the last written values as described above.

Test Plan:
- Reset, then ALU op ex_rd=3, ex_res=0x0000_00AA -> 1 cycle later wb_we=1, wb_rd=3, wb_wbv=0xAA, wb_cnt=1; ex_ready stays 1.
- Three back-to-back ALU ops rd=1,2,3 with values 0x11,0x22,0x33 -> three consecutive wb_we pulses in order; wb_cnt=3.
- Load rd=5; mem_rsp_data=0xDEAD_BEEF on the 4th cycle in WAIT_LD -> ex_ready=0 during the wait; next cycle wb_we=1, wb_rd=5, wb_wbv=0xDEADBEEF; ex_ready=1 again.
- Load rd=7 with no response, LD_TIMEOUT=15 -> after 15 cycles ld_err=1, no wb_we, return to IDLE; a following ALU op still writes normally and ld_err stays 1.
- ALU op rd=0, value 0x55 -> wb_we stays 0, wb_cnt unchanged. With WB_SANITIZE_EN defined: wb_wbv reads 0 in all non-write cycles.
- Assert rst_n=0 mid WAIT_LD, release, then pulse mem_rsp_valid -> all outputs 0, no write, ex_ready=1.
